// File: rtl/swo_uart_rx.sv
// swo_uart_rx: 8N1 NRZ receiver for the SWO trace pin.
// Oversamples swo on trace_clk, recovers bytes at a programmable bit period,
// and hands them to the capture path through a one-deep holding register.
module swo_uart_rx #(
  parameter int pDIV_WIDTH = 12
) (
  input  logic                  trace_clk,
  input  logic                  reset,
  input  logic                  swo,
  input  logic                  I_swo_enable,
  input  logic [pDIV_WIDTH-1:0] I_swo_div,
  input  logic                  I_data_ready,
  input  logic                  I_clear_errors,
  output logic [7:0]            O_data,
  output logic                  O_data_valid,
  output logic                  O_busy,
  output logic                  O_framing_error,
  output logic                  O_overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_s1, r_s2, r_s3;
  logic [pDIV_WIDTH-1:0] r_div_l, r_cnt;
  logic [pDIV_WIDTH-1:0] w_div_clamp, w_cnt_load;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;
  logic                  w_start, w_sample, w_load, w_shift_en;
  logic                  w_deliver, w_frame_err, w_accept, w_overrun_set;

  // Divisors below 3 leave too little room around the mid-bit sample point.
  assign w_div_clamp = (I_swo_div < pDIV_WIDTH'(3)) ? pDIV_WIDTH'(3) : I_swo_div;
  assign w_start     = (r_state == ST_IDLE) & I_swo_enable & r_s3 & ~r_s2;
  assign w_sample    = (r_cnt == '0);

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= swo;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // State register; busy is registered alongside it.
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      O_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      O_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cnt_load  = r_div_l;
    w_shift_en  = 1'b0;
    w_deliver   = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_START;
          w_load      = 1'b1;
          w_cnt_load  = w_div_clamp >> 1;
        end
      end
      ST_START: begin
        if (w_sample) begin
          if (r_s2) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
            w_load      = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_sample) begin
          w_shift_en = 1'b1;
          w_load     = 1'b1;
          if (r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_sample) begin
          w_state_nxt = ST_IDLE;
          w_deliver   = r_s2;
          w_frame_err = ~r_s2;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Disable aborts any frame in flight without side effects.
    if (!I_swo_enable) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b0;
      w_shift_en  = 1'b0;
      w_deliver   = 1'b0;
      w_frame_err = 1'b0;
    end
  end

  // Bit timing: divisor latch, sample counter, bit index and shift register.
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      r_div_l   <= '0;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_start) r_div_l <= w_div_clamp;
      if (w_load)              r_cnt <= w_cnt_load;
      else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
      if (r_state == ST_START) r_bit_idx <= '0;
      else if (w_shift_en)     r_bit_idx <= r_bit_idx + 1'b1;
      if (!I_swo_enable)       r_shift <= '0;
      else if (w_shift_en)     r_shift <= {r_s2, r_shift[7:1]};
    end
  end

  // A byte lands if the holder is empty or being drained this same cycle.
  assign w_accept      = w_deliver & (~O_data_valid | I_data_ready);
  assign w_overrun_set = w_deliver & O_data_valid & ~I_data_ready;

  // Holding register with valid/ready handshake.
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      O_data       <= '0;
      O_data_valid <= 1'b0;
    end else if (w_accept) begin
      O_data       <= r_shift;
      O_data_valid <= 1'b1;
    end else if (O_data_valid & I_data_ready) begin
      O_data_valid <= 1'b0;
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      O_framing_error <= 1'b0;
      O_overrun       <= 1'b0;
    end else begin
      O_framing_error <= (O_framing_error & ~I_clear_errors) | w_frame_err;
      O_overrun       <= (O_overrun & ~I_clear_errors) | w_overrun_set;
    end
  end

endmodule

// File: tb/tb_swo_uart_rx.sv
// Directed bench for swo_uart_rx: bytes are scoreboarded when sent and
// checked when the DUT hands them over on valid/ready.
module tb_swo_uart_rx;

  logic        trace_clk;
  logic        reset;
  logic        swo;
  logic        I_swo_enable;
  logic [11:0] I_swo_div;
  logic        I_data_ready;
  logic        I_clear_errors;
  logic [7:0]  O_data;
  logic        O_data_valid;
  logic        O_busy;
  logic        O_framing_error;
  logic        O_overrun;

  swo_uart_rx #(.pDIV_WIDTH(12)) dut (
    .trace_clk       (trace_clk),
    .reset           (reset),
    .swo             (swo),
    .I_swo_enable    (I_swo_enable),
    .I_swo_div       (I_swo_div),
    .I_data_ready    (I_data_ready),
    .I_clear_errors  (I_clear_errors),
    .O_data          (O_data),
    .O_data_valid    (O_data_valid),
    .O_busy          (O_busy),
    .O_framing_error (O_framing_error),
    .O_overrun       (O_overrun)
  );

  initial trace_clk = 1'b0;
  always #5 trace_clk = ~trace_clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  logic [7:0] exp_q[$];
  int         xq[$];

  always @(posedge trace_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every transfer must match the oldest pending byte.
  always @(negedge trace_clk) begin
    if (reset === 1'b0 && O_data_valid === 1'b1 && I_data_ready === 1'b1) begin
      xq.push_back(cyc);
      if (exp_q.size() == 0) chk("extra_byte", 32'(exp_q.size()), 32'd1);
      else chk("rx_data", {24'd0, O_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge trace_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int bitc, input logic stop_v,
                           input int chg_bit = -1, input logic [11:0] chg_div = 12'd0);
    swo = 1'b0;
    tick(bitc);
    for (int i = 0; i < 8; i++) begin
      if (i == chg_bit) I_swo_div = chg_div;
      swo = b[i];
      tick(bitc);
    end
    swo = stop_v;
    tick(bitc);
  endtask

  task automatic pulse_clear();
    I_clear_errors = 1'b1;
    tick(1);
    I_clear_errors = 1'b0;
  endtask

  int c0;

  initial begin
    reset = 1'b1; swo = 1'b1; I_swo_enable = 1'b0; I_swo_div = 12'd15;
    I_data_ready = 1'b0; I_clear_errors = 1'b0;
    tick(3);
    chk("rst_data",  {24'd0, O_data}, 32'd0);
    chk("rst_valid", {31'd0, O_data_valid}, 32'd0);
    chk("rst_busy",  {31'd0, O_busy}, 32'd0);
    chk("rst_fe",    {31'd0, O_framing_error}, 32'd0);
    chk("rst_ov",    {31'd0, O_overrun}, 32'd0);
    reset = 1'b0; I_swo_enable = 1'b1; I_data_ready = 1'b1;
    tick(5);

    // Single byte with latency measurement.
    xq.delete();
    exp_q.push_back(8'hA5);
    c0 = cyc;
    send_byte(8'hA5, 16, 1'b1);
    tick(10);
    chk("single_cnt", 32'(xq.size()), 32'd1);
    if (xq.size() == 1) chk("single_latency", 32'(xq[0] - c0 - 1), 32'd154);
    chk("single_fe", {31'd0, O_framing_error}, 32'd0);
    chk("single_ov", {31'd0, O_overrun}, 32'd0);

    // Back-to-back frames with no idle between them.
    xq.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
    send_byte(8'h00, 16, 1'b1);
    send_byte(8'hFF, 16, 1'b1);
    send_byte(8'h3C, 16, 1'b1);
    tick(10);
    chk("b2b_cnt", 32'(xq.size()), 32'd3);
    if (xq.size() == 3) begin
      chk("b2b_gap1", 32'(xq[1] - xq[0]), 32'd160);
      chk("b2b_gap2", 32'(xq[2] - xq[1]), 32'd160);
    end

    // Overrun: second byte dropped while the first is held.
    I_data_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 16, 1'b1);
    send_byte(8'h22, 16, 1'b1);
    tick(5);
    chk("ovr_data",  {24'd0, O_data}, 32'h11);
    chk("ovr_valid", {31'd0, O_data_valid}, 32'd1);
    chk("ovr_flag",  {31'd0, O_overrun}, 32'd1);
    I_data_ready = 1'b1;
    tick(1);
    chk("ovr_drain", {31'd0, O_data_valid}, 32'd0);
    chk("ovr_qempty", 32'(exp_q.size()), 32'd0);
    pulse_clear();
    chk("ovr_clear", {31'd0, O_overrun}, 32'd0);

    // Framing error with the line then held low (break).
    send_byte(8'h55, 16, 1'b0);
    tick(200);
    chk("fe_flag",  {31'd0, O_framing_error}, 32'd1);
    chk("fe_valid", {31'd0, O_data_valid}, 32'd0);
    chk("fe_busy",  {31'd0, O_busy}, 32'd0);
    swo = 1'b1;
    tick(40);
    chk("fe_busy2", {31'd0, O_busy}, 32'd0);
    pulse_clear();
    chk("fe_clear", {31'd0, O_framing_error}, 32'd0);

    // Short low glitch: false start.
    swo = 1'b0;
    tick(4);
    swo = 1'b1;
    chk("glitch_busy", {31'd0, O_busy}, 32'd1);
    tick(20);
    chk("glitch_idle", {31'd0, O_busy}, 32'd0);
    chk("glitch_fe",   {31'd0, O_framing_error}, 32'd0);
    chk("glitch_ov",   {31'd0, O_overrun}, 32'd0);

    // Divisor 0 clamps to 4 cycles per bit.
    I_swo_div = 12'd0;
    exp_q.push_back(8'hC3); exp_q.push_back(8'h5A);
    send_byte(8'hC3, 4, 1'b1);
    send_byte(8'h5A, 4, 1'b1);
    tick(10);
    chk("clamp_qempty", 32'(exp_q.size()), 32'd0);

    // Divisor change mid-frame does not affect the current frame.
    I_swo_div = 12'd15;
    tick(5);
    exp_q.push_back(8'h96);
    send_byte(8'h96, 16, 1'b1, 3, 12'd7);
    tick(10);
    chk("divchg_qempty", 32'(exp_q.size()), 32'd0);
    chk("divchg_fe", {31'd0, O_framing_error}, 32'd0);
    I_swo_div = 12'd15;
    tick(5);

    // Reset during DATA clears everything, including a held byte.
    I_data_ready = 1'b0;
    send_byte(8'h9C, 16, 1'b1);
    tick(5);
    chk("rstm_held", {24'd0, O_data}, 32'h9C);
    swo = 1'b0;
    tick(40);
    chk("rstm_busy_pre", {31'd0, O_busy}, 32'd1);
    reset = 1'b1; swo = 1'b1;
    tick(1);
    chk("rstm_data",  {24'd0, O_data}, 32'd0);
    chk("rstm_valid", {31'd0, O_data_valid}, 32'd0);
    chk("rstm_busy",  {31'd0, O_busy}, 32'd0);
    reset = 1'b0;
    tick(20);

    // Disable mid-frame: held byte retained, partial byte discarded.
    exp_q.push_back(8'h77);
    send_byte(8'h77, 16, 1'b1);
    tick(5);
    swo = 1'b0; tick(16);
    swo = 1'b1; tick(16);
    swo = 1'b0; tick(8);
    I_swo_enable = 1'b0;
    tick(1);
    chk("dis_busy",  {31'd0, O_busy}, 32'd0);
    chk("dis_valid", {31'd0, O_data_valid}, 32'd1);
    chk("dis_data",  {24'd0, O_data}, 32'h77);
    tick(8);
    swo = 1'b1;
    tick(120);
    I_swo_enable = 1'b1;
    tick(30);
    chk("dis_busy2", {31'd0, O_busy}, 32'd0);
    chk("dis_data2", {24'd0, O_data}, 32'h77);
    chk("dis_ov",    {31'd0, O_overrun}, 32'd0);
    I_data_ready = 1'b1;
    tick(3);
    chk("dis_drain", {31'd0, O_data_valid}, 32'd0);

    tick(10);
    chk("final_qempty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
